// File: rtl/aes_pkg.sv
// Shared AES decryption helpers: FSM encoding, inverse S-box, GF(2^8) doubling, round count.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Inverse S-box, entry x at bits [8x : 8x+7].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul4(input logic [7:0] x);
    return gf_mul2(gf_mul2(x));
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] x);
    return gf_mul2(gf_mul4(x));
  endfunction

  function automatic int nr_from_key_bits(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns.
// Byte i of the state sits at bits [8i : 8i+7]; row = i%4, column = i/4.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  input  logic         skip_mix,
  output logic [0:127] state_out
);

  logic [0:127] shifted;
  logic [0:127] keyed;
  logic [0:127] mixed;

  // Row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[8*(4*c+r) +: 8] = state_in[8*(4*((c-r+4)%4)+r) +: 8];
      end
    end
  end

  // Byte substitution followed by the round key.
  always_comb begin
    keyed = '0;
    for (int i = 0; i < 16; i++) begin
      keyed[8*i +: 8] = inv_sbox(shifted[8*i +: 8]) ^ round_key[8*i +: 8];
    end
  end

  // Column mix by {0e,0b,0d,09}, built from x2/x4/x8 terms.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[32*c      +: 8];
      a1 = keyed[32*c + 8  +: 8];
      a2 = keyed[32*c + 16 +: 8];
      a3 = keyed[32*c + 24 +: 8];
      mixed[32*c      +: 8] = (gf_mul8(a0) ^ gf_mul4(a0) ^ gf_mul2(a0)) ^ (gf_mul8(a1) ^ gf_mul2(a1) ^ a1)
                            ^ (gf_mul8(a2) ^ gf_mul4(a2) ^ a2) ^ (gf_mul8(a3) ^ a3);
      mixed[32*c + 8  +: 8] = (gf_mul8(a0) ^ a0) ^ (gf_mul8(a1) ^ gf_mul4(a1) ^ gf_mul2(a1))
                            ^ (gf_mul8(a2) ^ gf_mul2(a2) ^ a2) ^ (gf_mul8(a3) ^ gf_mul4(a3) ^ a3);
      mixed[32*c + 16 +: 8] = (gf_mul8(a0) ^ gf_mul4(a0) ^ a0) ^ (gf_mul8(a1) ^ a1)
                            ^ (gf_mul8(a2) ^ gf_mul4(a2) ^ gf_mul2(a2)) ^ (gf_mul8(a3) ^ gf_mul2(a3) ^ a3);
      mixed[32*c + 24 +: 8] = (gf_mul8(a0) ^ gf_mul2(a0) ^ a0) ^ (gf_mul8(a1) ^ gf_mul4(a1) ^ a1)
                            ^ (gf_mul8(a2) ^ a2) ^ (gf_mul8(a3) ^ gf_mul4(a3) ^ gf_mul2(a3));
    end
  end

  assign state_out = skip_mix ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
//
//  state | meaning
//  IDLE  | waiting for a ciphertext block, rk_idx = NR
//  INIT  | initial AddRoundKey with round key NR
//  ROUND | full inverse round using round key cnt (NR-1 down to 1)
//  FINAL | last round without InvMixColumns, round key 0, result registered
//  DONE  | plaintext held until taken; may accept the next block in the same cycle
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:127]     in_data,
  output logic [IDX_W-1:0] rk_idx,
  input  logic [0:127]     rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:127]     out_data,
  output logic             busy
);

  localparam int NR = nr_from_key_bits(KEY_BITS);
  localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_inv_cipher_core: KEY_BITS must be 128, 192 or 256");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [0:127]     data_q, data_d;
  logic [0:127]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skip_mix;
  logic [0:127]     round_out;

  aes_inv_round u_round (
    .state_in  (data_q),
    .round_key (rk_data),
    .skip_mix  (skip_mix),
    .state_out (round_out)
  );

  // State, counter, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= NR_IDX;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; rk_idx depends only on registered state and counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    rk_idx      = NR_IDX;
    skip_mix    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = NR_IDX;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        data_d  = data_q ^ rk_data;
        cnt_d   = NR_IDX - 1'b1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        rk_idx = cnt_q;
        data_d = round_out;
        if (cnt_q == IDX_W'(1)) begin
          state_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FINAL: begin
        rk_idx      = '0;
        skip_mix    = 1'b1;
        data_d      = round_out;
        out_data_d  = round_out;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            data_d  = in_data;
            cnt_d   = NR_IDX;
            state_d = ST_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Directed bench: one core per key size, round keys expanded by the bench from FIPS-197 keys.
module tb_aes_inv_cipher_core;

  localparam logic [0:127] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [0:127] in_data   [3];
  logic [3:0]   rk_idx    [3];
  logic [0:127] rk_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [0:127] out_data  [3];
  logic         busy      [3];

  logic [0:127] rks [3][16];
  logic [7:0]   sbox [256];
  int           n_checks;
  int           n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_cipher_core #(.KEY_BITS(128 + 64*g), .IDX_W(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .rk_idx    (rk_idx[g]),
      .rk_data   (rk_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
    assign rk_data[g] = rks[g][rk_idx[g]];
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from the field inverse and the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [0:127] round_key(input int nk, input logic [0:255] key, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Offer one block, measure edges from accept (counted as 1) to out_valid, check result.
  task automatic run_block(input int d, input logic [0:127] ct, input int nr, input bit trace,
                           input string tag);
    int n;
    int lat;
    n = 0;
    while (!in_ready[d] && n < 50) begin tick(); n++; end
    check({tag, "_in_ready"}, in_ready[d], 1);
    in_valid[d] = 1'b1;
    in_data[d]  = ct;
    tick();
    in_valid[d] = 1'b0;
    lat = 1;
    while (!out_valid[d] && lat < 64) begin
      if (trace && lat <= nr + 1)
        check($sformatf("%s_rk_idx[%0d]", tag, lat), rk_idx[d], nr + 1 - lat);
      in_data[d] = rand128();
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, nr + 2);
    check({tag, "_out_data"}, out_data[d], PT);
    tick();
    check({tag, "_valid_drop"}, out_valid[d], 0);
  endtask

  task automatic test_backpressure();
    int n;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = CT128;
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 64) begin tick(); n++; end
    check("bp_valid_seen", out_valid[0], 1);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp_hold_valid[%0d]", i), out_valid[0], 1);
      check($sformatf("bp_hold_data[%0d]", i), out_data[0], PT);
      check($sformatf("bp_in_ready[%0d]", i), in_ready[0], 0);
      tick();
    end
    check("bp_hold_valid_end", out_valid[0], 1);
    out_ready[0] = 1'b1;
    tick();
    check("bp_release_valid", out_valid[0], 0);
    check("bp_release_in_ready", in_ready[0], 1);
    check("bp_release_busy", busy[0], 0);
    tick();
    check("bp_single_transfer", out_valid[0], 0);
  endtask

  // With out_ready high, blocks chain INIT, NR-1 ROUND, FINAL, DONE: NR+2 cycles apart.
  task automatic test_back_to_back();
    int cyc;
    int seen;
    int t_prev;
    cyc = 0; seen = 0; t_prev = 0;
    in_valid[0]  = 1'b1;
    in_data[0]   = CT128;
    out_ready[0] = 1'b1;
    while (seen < 3 && cyc < 100) begin
      tick();
      cyc++;
      if (out_valid[0]) begin
        check($sformatf("b2b_data[%0d]", seen), out_data[0], PT);
        check($sformatf("b2b_accept_in_done[%0d]", seen), in_ready[0], 1);
        if (seen > 0) check($sformatf("b2b_period[%0d]", seen), cyc - t_prev, 12);
        t_prev = cyc;
        seen++;
        if (seen == 3) in_valid[0] = 1'b0;
      end
    end
    check("b2b_count", seen, 3);
    tick();
    check("b2b_idle_after", busy[0], 0);
  endtask

  task automatic test_mid_reset();
    int n_pulse;
    in_valid[0] = 1'b1;
    in_data[0]  = CT128;
    tick();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_pre_cnt", rk_idx[0], 5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_out_valid", out_valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_rk_idx", rk_idx[0], 10);
    check("rst_out_data", out_data[0], 0);
    n_pulse = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid[0]) n_pulse++;
      tick();
    end
    check("rst_no_pulse", n_pulse, 0);
    run_block(0, CT128, 10, 1'b0, "rst_after");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clk      = 1'b0;
    rst      = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
      for (int r = 0; r < 16; r++) rks[d][r] = '0;
    end
    build_sbox();
    for (int r = 0; r <= 10; r++) rks[0][r] = round_key(4, KEY128, r);
    for (int r = 0; r <= 12; r++) rks[1][r] = round_key(6, KEY192, r);
    for (int r = 0; r <= 14; r++) rks[2][r] = round_key(8, KEY256, r);

    tick();
    tick();
    check("reset_out_valid", out_valid[0], 0);
    check("reset_out_data", out_data[0], 0);
    check("reset_busy", busy[0], 0);
    check("reset_in_ready", in_ready[0], 1);
    check("reset_rk_idx_128", rk_idx[0], 10);
    check("reset_rk_idx_192", rk_idx[1], 12);
    check("reset_rk_idx_256", rk_idx[2], 14);
    rst = 1'b1;
    tick();

    run_block(0, CT128, 10, 1'b1, "aes128");
    run_block(1, CT192, 12, 1'b0, "aes192");
    run_block(2, CT256, 14, 1'b0, "aes256");
    test_backpressure();
    test_back_to_back();
    test_mid_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
